sd_sector_packer: RTL and testbench

- Sits directly downstream of the SD sector-read controller, in the same 50 MHz SD clock domain as the sector-sequencing FSM.
- Consumes the controller's 16-bit read-data strobe stream, repacks halfwords into little-endian 32-bit words and buffers them in a small FIFO.
- Presents the words as a valid/ready stream to the DMA write side.
- Tracks words per sector and sectors per transfer, and flags the transfer end and any data loss.

---
 rtl/sd_pkg.sv | 21 ++
 rtl/sd_sector_packer_if.sv | 21 ++
 rtl/sd_word_fifo.sv | 66 ++++++
 rtl/sd_sector_packer.sv | 178 +++++++++++++++++
 tb/tb_sd_sector_packer.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sd_pkg.sv
// Shared constants, FSM state type and halfword packing helper for the
// SD sector read-data packer.
package sd_pkg;

    localparam int SEC_BYTES = 512;
    localparam int SEC_WORDS = SEC_BYTES / 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pack_state_t;

    // The SD card delivers the first byte of each halfword in [15:8]; the
    // DMA side wants the byte stream laid out little-endian in 32 bits.
    function automatic logic [31:0] pack_halfwords(input logic [15:0] hw0,
                                                   input logic [15:0] hw1);
        return {hw1[7:0], hw1[15:8], hw0[7:0], hw0[15:8]};
    endfunction

endpackage

// File: rtl/sd_sector_packer_if.sv
// Packed-word valid/ready stream from the sector packer to the DMA writer.
interface sd_sector_packer_if;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/sd_word_fifo.sv
// First-word-fall-through FIFO: the head entry is visible the cycle after it
// is written. Pushes into a full FIFO are dropped, even with a pop pending.
module sd_word_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 33
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok;
    logic             pop_ok;

    assign full      = (level_q == (AW+1)'(DEPTH));
    assign empty     = (level_q == '0);
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // Pointer and occupancy update; pointers wrap naturally at DEPTH.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Pointer and level registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because empty gates the outputs.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sd_sector_packer.sv
// Repacks the SD read-controller halfword strobe stream into little-endian
// 32-bit words, buffers them and tracks sector/transfer progress.
module sd_sector_packer #(
    parameter int FIFO_DEPTH = 16,
    parameter int SEC_WORDS  = sd_pkg::SEC_WORDS,
    parameter int CNT_W      = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          xfer_start,
    input  logic [CNT_W-1:0]              xfer_sec_counts,
    input  logic                          rd_val_en,
    input  logic [15:0]                   rd_val_data,
    sd_sector_packer_if.master            m,
    output logic                          sec_done,
    output logic                          xfer_done,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    import sd_pkg::*;

    localparam int WC_W = $clog2(SEC_WORDS);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(SEC_WORDS - 1);

    pack_state_t      state_q, state_d;
    logic             busy_q, busy_d;
    logic             zero_pend_q, zero_pend_d;
    logic             phase_q, phase_d;
    logic [15:0]      hw0_q, hw0_d;
    logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
    logic [CNT_W-1:0] sec_cnt_q, sec_cnt_d;
    logic [CNT_W-1:0] last_sec_q, last_sec_d;
    logic             overflow_q, overflow_d;
    logic             sec_done_q, sec_done_d;
    logic             xfer_done_q, xfer_done_d;

    logic             fifo_push;
    logic [32:0]      fifo_wdata;
    logic             fifo_pop;
    logic [32:0]      fifo_head;
    logic             fifo_full;
    logic             fifo_empty;

    sd_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (33)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (fifo_wdata),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Outputs are forced to zero when empty so stale storage never shows.
    assign m.m_valid = !fifo_empty;
    assign m.m_data  = fifo_empty ? 32'h0 : fifo_head[31:0];
    assign m.m_last  = !fifo_empty && fifo_head[32];
    assign fifo_pop  = m.m_valid && m.m_ready;

    assign sec_done  = sec_done_q;
    assign xfer_done = xfer_done_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

    // Next-state, counter and FIFO-push logic for the packer FSM.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        zero_pend_d = 1'b0;
        phase_d     = phase_q;
        hw0_d       = hw0_q;
        word_cnt_d  = word_cnt_q;
        sec_cnt_d   = sec_cnt_q;
        last_sec_d  = last_sec_q;
        overflow_d  = overflow_q;
        sec_done_d  = 1'b0;
        xfer_done_d = 1'b0;
        fifo_push   = 1'b0;
        fifo_wdata  = {1'b0, pack_halfwords(hw0_q, rd_val_data)};

        case (state_q)
            IDLE: begin
                if (zero_pend_q) begin
                    // Zero-sector transfer: one busy cycle, then done.
                    busy_d      = 1'b0;
                    xfer_done_d = 1'b1;
                end else if (xfer_start && !busy_q) begin
                    overflow_d = 1'b0;
                    busy_d     = 1'b1;
                    if (xfer_sec_counts != '0) begin
                        state_d    = RUN;
                        last_sec_d = xfer_sec_counts - CNT_W'(1);
                        word_cnt_d = '0;
                        sec_cnt_d  = '0;
                        phase_d    = 1'b0;
                    end else begin
                        zero_pend_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (rd_val_en) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        hw0_d = rd_val_data;
                    end else begin
                        // Counters advance even if the word is dropped, so a
                        // transfer with overflow still reaches DRAIN.
                        fifo_push = 1'b1;
                        if (fifo_full) begin
                            overflow_d = 1'b1;
                        end
                        if (word_cnt_q == WC_MAX) begin
                            word_cnt_d = '0;
                            sec_done_d = 1'b1;
                            sec_cnt_d  = sec_cnt_q + CNT_W'(1);
                            if (sec_cnt_q == last_sec_q) begin
                                fifo_wdata[32] = 1'b1;
                                state_d        = DRAIN;
                            end
                        end else begin
                            word_cnt_d = word_cnt_q + WC_W'(1);
                        end
                    end
                end
            end

            DRAIN: begin
                if (fifo_pop && fifo_head[32]) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    xfer_done_d = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            zero_pend_q <= 1'b0;
            phase_q     <= 1'b0;
            hw0_q       <= '0;
            word_cnt_q  <= '0;
            sec_cnt_q   <= '0;
            last_sec_q  <= '0;
            overflow_q  <= 1'b0;
            sec_done_q  <= 1'b0;
            xfer_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            zero_pend_q <= zero_pend_d;
            phase_q     <= phase_d;
            hw0_q       <= hw0_d;
            word_cnt_q  <= word_cnt_d;
            sec_cnt_q   <= sec_cnt_d;
            last_sec_q  <= last_sec_d;
            overflow_q  <= overflow_d;
            sec_done_q  <= sec_done_d;
            xfer_done_q <= xfer_done_d;
        end
    end

endmodule

// File: tb/tb_sd_sector_packer.sv
// Directed and randomized checks of sd_sector_packer against a byte-stream
// reference model.
module tb_sd_sector_packer;
    localparam int FIFO_DEPTH = 16;
    localparam int SEC_WORDS  = 128;
    localparam int CNT_W      = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             xfer_start = 1'b0;
    logic [CNT_W-1:0] xfer_sec_counts = '0;
    logic             rd_val_en = 1'b0;
    logic [15:0]      rd_val_data = '0;
    logic             sec_done;
    logic             xfer_done;
    logic             busy;
    logic             overflow;
    logic [4:0]       fifo_level;

    sd_sector_packer_if mif ();

    sd_sector_packer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SEC_WORDS  (SEC_WORDS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .xfer_start      (xfer_start),
        .xfer_sec_counts (xfer_sec_counts),
        .rd_val_en       (rd_val_en),
        .rd_val_data     (rd_val_data),
        .m               (mif),
        .sec_done        (sec_done),
        .xfer_done       (xfer_done),
        .busy            (busy),
        .overflow        (overflow),
        .fifo_level      (fifo_level)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_sec = 0;
    int          n_xd = 0;
    int          n_valid_seen = 0;
    int          cyc = 0;
    int          xd_cyc = -1;
    int          last_pop_cyc = -1;
    logic [32:0] got [$];
    logic [15:0] hw_q [$];
    bit          hold_pend = 1'b0;
    logic [31:0] hold_data = '0;
    logic        hold_last = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor: counts pulses, records popped words, checks hold stability.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (hold_pend) begin
                check("hold_valid", 64'(mif.m_valid), 64'd1);
                check("hold_data", 64'(mif.m_data), 64'(hold_data));
                check("hold_last", 64'(mif.m_last), 64'(hold_last));
            end
            if (sec_done) n_sec++;
            if (xfer_done) begin
                n_xd++;
                xd_cyc = cyc;
            end
            if (mif.m_valid) n_valid_seen++;
            if (mif.m_valid && mif.m_ready) begin
                got.push_back({mif.m_last, mif.m_data});
                last_pop_cyc = cyc;
            end
        end
        hold_pend = mif.m_valid && !mif.m_ready && !rst;
        hold_data = mif.m_data;
        hold_last = mif.m_last;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    // Reference model: the SD byte stream, byte n of the transfer.
    function automatic logic [7:0] sd_byte(input int n);
        logic [15:0] h;
        h = hw_q[n / 2];
        return (n % 2 == 0) ? h[15:8] : h[7:0];
    endfunction

    // Word k is bytes 4k..4k+3 of the stream, little-endian.
    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w = w | (32'(sd_byte(4 * k + j)) << (8 * j));
        end
        return w;
    endfunction

    task automatic check_words(input int total, input int n_check);
        for (int k = 0; k < n_check && k < got.size(); k++) begin
            check($sformatf("word%0d_data", k), 64'(got[k][31:0]), 64'(exp_word(k)));
            check($sformatf("word%0d_last", k), 64'(got[k][32]), 64'(k == total - 1));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        n_sec = 0;
        n_xd = 0;
        n_valid_seen = 0;
        xd_cyc = -1;
        last_pop_cyc = -1;
        got.delete();
        hw_q.delete();
    endtask

    task automatic set_ready(input int rmode, input int c);
        if (rmode == 0) mif.m_ready = 1'b1;
        else if (rmode == 1) mif.m_ready = (c % 2 == 0);
        else mif.m_ready = 1'b0;
    endtask

    task automatic start(input int cnt);
        xfer_start = 1'b1;
        xfer_sec_counts = CNT_W'(cnt);
        tick();
        xfer_start = 1'b0;
    endtask

    // Streams halfwords; gap idle cycles between strobes. Optionally stops
    // early (after stop_pops words with an odd halfword count) or injects a
    // count=5 start at halfword start_at.
    task automatic drive(input int n_hw, input int gap, input int rmode, input bit rnd,
                         input int stop_pops, input int start_at);
        int idx;
        int c;
        logic [15:0] h;
        idx = 0;
        c = 0;
        while (idx < n_hw && c < 20000) begin
            if (stop_pops > 0 && got.size() >= stop_pops && idx % 2 == 1) break;
            set_ready(rmode, c);
            xfer_start = 1'b0;
            if (c % (gap + 1) == 0) begin
                h = rnd ? 16'($urandom) : {8'(2 * idx), 8'(2 * idx + 1)};
                rd_val_en = 1'b1;
                rd_val_data = h;
                hw_q.push_back(h);
                if (idx == start_at) begin
                    xfer_start = 1'b1;
                    xfer_sec_counts = CNT_W'(5);
                end
                idx++;
            end else begin
                rd_val_en = 1'b0;
            end
            tick();
            c++;
        end
        rd_val_en = 1'b0;
        xfer_start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input int rmode);
        for (int c = 0; c < limit; c++) begin
            if (n_xd >= 1) break;
            set_ready(rmode, c);
            tick();
        end
        tick();
        mif.m_ready = 1'b1;
        check("xfer_done_count", 64'(n_xd), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_val_en = 1'b0;
        xfer_start = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        mif.m_ready = 1'b1;
        tick();
        do_reset();
        check("rst_m_valid", 64'(mif.m_valid), 64'd0);
        check("rst_m_data", 64'(mif.m_data), 64'd0);
        check("rst_m_last", 64'(mif.m_last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_fifo_level", 64'(fifo_level), 64'd0);
        check("rst_sec_done", 64'(sec_done), 64'd0);
        check("rst_xfer_done", 64'(xfer_done), 64'd0);

        // Single sector, sequential byte pattern, always ready.
        clear_stats();
        start(1);
        check("t1_busy", 64'(busy), 64'd1);
        drive(256, 0, 0, 1'b0, 0, -1);
        wait_done(300, 0);
        check("t1_words", 64'(got.size()), 64'd128);
        if (got.size() > 0) check("t1_first_word", 64'(got[0][31:0]), 64'h03020100);
        check_words(128, 128);
        check("t1_sec_done", 64'(n_sec), 64'd1);
        check("t1_done_lag", 64'(xd_cyc - last_pop_cyc), 64'd1);
        check("t1_busy_end", 64'(busy), 64'd0);

        // Three sectors, random data, sparse strobes, toggling ready.
        clear_stats();
        start(3);
        drive(768, 1, 1, 1'b1, 0, -1);
        wait_done(400, 1);
        check("t2_words", 64'(got.size()), 64'd384);
        check_words(384, 384);
        check("t2_sec_done", 64'(n_sec), 64'd3);
        check("t2_overflow", 64'(overflow), 64'd0);
        check("t2_busy_end", 64'(busy), 64'd0);

        // Overflow: no ready while a whole sector streams in.
        clear_stats();
        start(1);
        drive(256, 0, 2, 1'b1, 0, -1);
        tick();
        check("t3_level", 64'(fifo_level), 64'd16);
        check("t3_overflow", 64'(overflow), 64'd1);
        check("t3_busy", 64'(busy), 64'd1);
        check("t3_no_pops", 64'(got.size()), 64'd0);
        check("t3_sec_done", 64'(n_sec), 64'd1);
        mif.m_ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("t3_words", 64'(got.size()), 64'd16);
        check_words(128, 16);
        check("t3_no_xfer_done", 64'(n_xd), 64'd0);
        check("t3_busy_after", 64'(busy), 64'd1);
        check("t3_level_after", 64'(fifo_level), 64'd0);
        do_reset();
        check("t3_rst_busy", 64'(busy), 64'd0);
        check("t3_rst_overflow", 64'(overflow), 64'd0);

        // Zero-sector transfer.
        clear_stats();
        start(0);
        check("t4_busy_pulse", 64'(busy), 64'd1);
        check("t4_done_early", 64'(xfer_done), 64'd0);
        tick();
        check("t4_busy_clear", 64'(busy), 64'd0);
        check("t4_done_pulse", 64'(xfer_done), 64'd1);
        tick();
        check("t4_done_single", 64'(xfer_done), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t4_no_valid", 64'(n_valid_seen), 64'd0);
        check("t4_no_sec_done", 64'(n_sec), 64'd0);
        check("t4_xfer_done_count", 64'(n_xd), 64'd1);

        // Start request with count=5 during a count=2 transfer is ignored.
        clear_stats();
        start(2);
        drive(512, 0, 0, 1'b1, 0, 100);
        wait_done(300, 0);
        check("t5_words", 64'(got.size()), 64'd256);
        check_words(256, 256);
        check("t5_sec_done", 64'(n_sec), 64'd2);
        check("t5_busy_end", 64'(busy), 64'd0);

        // Reset after 50 words with the halfword phase left odd.
        clear_stats();
        start(1);
        drive(256, 0, 0, 1'b1, 50, -1);
        check_words(128, 50);
        do_reset();
        check("t6_rst_valid", 64'(mif.m_valid), 64'd0);
        check("t6_rst_level", 64'(fifo_level), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_xfer_done", 64'(xfer_done), 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t6_no_xfer_done", 64'(n_xd), 64'd0);
        clear_stats();
        start(1);
        drive(256, 0, 0, 1'b1, 0, -1);
        wait_done(300, 0);
        check("t6_words", 64'(got.size()), 64'd128);
        check_words(128, 128);
        check("t6_sec_done", 64'(n_sec), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
